// File: rtl/tlk2711_pkg.sv
// ============================================================================
// Package : tlk2711_pkg
// Purpose : Shared types and constants for the TLK2711 RX buffer scheduler.
//           Holds the scheduler FSM state encoding, the bit indices of the
//           completion error field, and the width of a completion record.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package tlk2711_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_ARMED = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Bit positions inside the 2-bit completion error field
  localparam int ERR_LOSS = 0;
  localparam int ERR_TMO  = 1;

  // Completion record = {addr, bytes[31:0], frames[15:0], err[1:0]}
  localparam int STAT_META_W = 32 + 16 + 2;

  function automatic int stat_rec_width(input int addr_width);
    return addr_width + STAT_META_W;
  endfunction

endpackage : tlk2711_pkg

`default_nettype wire

// File: rtl/tlk2711_sched_fifo.sv
// ============================================================================
// Module  : tlk2711_sched_fifo
// Purpose : Synchronous first-word-fall-through FIFO used for the descriptor
//           ring and the completion status queue.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_flush       - synchronous flush (same effect as rst)
//           i_push/i_data - write port; ignored when full unless a pop is
//                           accepted in the same cycle
//           i_pop         - read advance; ignored when empty
//           o_data        - head entry (valid while o_empty = 0)
//           o_level       - number of stored entries
//           o_full/o_empty- occupancy flags
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tlk2711_sched_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (level_q == FULL_LVL);
  assign o_empty   = (level_q == '0);
  assign o_level   = level_q;
  assign o_data    = mem_q[rd_ptr_q];

  assign w_pop_ok  = i_pop & ~o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule : tlk2711_sched_fifo

`default_nettype wire

// File: rtl/tlk2711_rx_buf_sched.sv
// ============================================================================
// Module  : tlk2711_rx_buf_sched
// Purpose : Walks the TLK2711 RX link across a ring of software-supplied DDR
//           buffers. For each descriptor it pulses start/base-address into the
//           RX link, waits for end-of-packet, loss or timeout, and queues a
//           completion record {addr, bytes, frames, err} for the CPU side.
// Ports   : clk, rst           - clock, synchronous active-high reset
//           i_soft_rst         - flush FIFOs, FSM and snapshots
//           i_enable           - run level; low parks in IDLE after current buffer
//           i_timeout          - ARMED cycle limit (0 = no timeout)
//           i_desc_*/o_desc_ready - descriptor push (valid/ready)
//           o_rx_start/o_rx_base_addr/o_rx_soft_rst - RX link control
//           i_rx_interrupt/i_rx_total_packet/i_rx_body_num/i_loss_interrupt
//                              - RX link status
//           o_stat_*/i_stat_ready - completion record FWFT pop interface
//           o_busy, o_ring_level - FSM activity and descriptor count
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tlk2711_rx_buf_sched
  import tlk2711_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RING_DEPTH = 4,
  parameter int TMO_WIDTH  = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_soft_rst,
  input  logic                          i_enable,
  input  logic [TMO_WIDTH-1:0]          i_timeout,
  input  logic                          i_desc_valid,
  input  logic [ADDR_WIDTH-1:0]         i_desc_addr,
  output logic                          o_desc_ready,
  output logic                          o_rx_start,
  output logic [ADDR_WIDTH-1:0]         o_rx_base_addr,
  output logic                          o_rx_soft_rst,
  input  logic                          i_rx_interrupt,
  input  logic [31:0]                   i_rx_total_packet,
  input  logic [15:0]                   i_rx_body_num,
  input  logic                          i_loss_interrupt,
  output logic                          o_stat_valid,
  output logic [ADDR_WIDTH-1:0]         o_stat_addr,
  output logic [31:0]                   o_stat_bytes,
  output logic [15:0]                   o_stat_frames,
  output logic [1:0]                    o_stat_err,
  input  logic                          i_stat_ready,
  output logic                          o_busy,
  output logic [$clog2(RING_DEPTH):0]   o_ring_level
);

  localparam int STAT_W = stat_rec_width(ADDR_WIDTH);
  localparam int LVL_W  = $clog2(RING_DEPTH) + 1;

  sched_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           snap_total_q;
  logic [15:0]           snap_body_q;
  logic [TMO_WIDTH-1:0]  timer_q;
  logic                  rx_int_prev_q;
  logic [31:0]           bytes_q;
  logic [15:0]           frames_q;
  logic [1:0]            err_q;

  logic                  w_desc_push;
  logic                  w_desc_pop;
  logic [ADDR_WIDTH-1:0] w_desc_head;
  logic                  w_desc_full;
  logic                  w_desc_empty;
  logic [LVL_W-1:0]      w_desc_level;

  logic                  w_stat_push;
  logic [STAT_W-1:0]     w_stat_wdata;
  logic [STAT_W-1:0]     w_stat_rdata;
  logic                  w_stat_full;
  logic                  w_stat_empty;
  logic [LVL_W-1:0]      w_stat_level;

  logic                  w_rx_rise;
  logic                  w_tmo_hit;
  logic [1:0]            w_err_ev;
  logic                  w_done_ev;
  logic                  w_load_base;
  logic                  w_rx_start;
  logic                  w_rx_soft_rst;

  // --------------------------------------------------------------------------
  // Descriptor ring
  // --------------------------------------------------------------------------
  assign o_desc_ready = ~w_desc_full;
  assign w_desc_push  = i_desc_valid & ~w_desc_full;

  tlk2711_sched_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (RING_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_soft_rst),
    .i_push  (w_desc_push),
    .i_data  (i_desc_addr),
    .i_pop   (w_desc_pop),
    .o_data  (w_desc_head),
    .o_level (w_desc_level),
    .o_full  (w_desc_full),
    .o_empty (w_desc_empty)
  );

  assign o_ring_level = w_desc_level;

  // --------------------------------------------------------------------------
  // Completion status queue
  // --------------------------------------------------------------------------
  assign w_stat_wdata = {base_q, bytes_q, frames_q, err_q};

  tlk2711_sched_fifo #(
    .WIDTH (STAT_W),
    .DEPTH (RING_DEPTH)
  ) u_stat_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_soft_rst),
    .i_push  (w_stat_push),
    .i_data  (w_stat_wdata),
    .i_pop   (i_stat_ready),
    .o_data  (w_stat_rdata),
    .o_level (w_stat_level),
    .o_full  (w_stat_full),
    .o_empty (w_stat_empty)
  );

  // Head fields read as zero while the queue holds nothing, so stale or
  // never-written storage is not exposed to the CPU side.
  assign o_stat_valid = ~w_stat_empty;
  always_comb begin
    {o_stat_addr, o_stat_bytes, o_stat_frames, o_stat_err} = '0;
    if (w_stat_level != '0) begin
      {o_stat_addr, o_stat_bytes, o_stat_frames, o_stat_err} = w_stat_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Completion events
  // --------------------------------------------------------------------------
  // The previous-value register follows the input continuously, so a level
  // still high from the last buffer is not mistaken for a new edge.
  assign w_rx_rise = i_rx_interrupt & ~rx_int_prev_q;
  assign w_tmo_hit = (i_timeout != '0) && (timer_q == i_timeout);

  always_comb begin
    w_err_ev           = '0;
    w_err_ev[ERR_LOSS] = i_loss_interrupt;
    w_err_ev[ERR_TMO]  = w_tmo_hit;
  end

  // Interrupt together with loss counts as a completion; the loss bit stands.
  assign w_done_ev = w_rx_rise | i_loss_interrupt | w_tmo_hit;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || i_soft_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    w_desc_pop    = 1'b0;
    w_stat_push   = 1'b0;
    w_load_base   = 1'b0;
    w_rx_start    = 1'b0;
    w_rx_soft_rst = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_enable && !w_desc_empty) begin
          state_d     = ST_START;
          w_load_base = 1'b1;
        end
      end
      ST_START: begin
        w_desc_pop = 1'b1;
        w_rx_start = 1'b1;
        state_d    = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_done_ev) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Hold here until the CPU makes room for the record.
        if (!w_stat_full) begin
          w_stat_push = 1'b1;
          if (err_q != 2'b00) begin
            w_rx_soft_rst = 1'b1;
            state_d       = ST_IDLE;
          end else if (i_enable && !w_desc_empty) begin
            state_d     = ST_START;
            w_load_base = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: base address, snapshots, timer, completion record
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || i_soft_rst) begin
      base_q        <= '0;
      snap_total_q  <= '0;
      snap_body_q   <= '0;
      timer_q       <= '0;
      rx_int_prev_q <= 1'b0;
      bytes_q       <= '0;
      frames_q      <= '0;
      err_q         <= '0;
    end else begin
      rx_int_prev_q <= i_rx_interrupt;

      // Base is captured on entry to START so it is already stable on the
      // start pulse; the same entry is popped during START.
      if (w_load_base) base_q <= w_desc_head;

      if (state_q == ST_START) begin
        snap_total_q <= i_rx_total_packet;
        snap_body_q  <= i_rx_body_num;
        timer_q      <= '0;
      end else if (state_q == ST_ARMED && timer_q != '1) begin
        timer_q <= timer_q + 1'b1;
      end

      // Modular differences: link counter wrap during a buffer is harmless.
      if (state_q == ST_ARMED && w_done_ev) begin
        bytes_q  <= i_rx_total_packet - snap_total_q;
        frames_q <= i_rx_body_num - snap_body_q;
        err_q    <= w_err_ev;
      end
    end
  end

  assign o_rx_start     = w_rx_start;
  assign o_rx_base_addr = base_q;
  assign o_rx_soft_rst  = w_rx_soft_rst;
  assign o_busy         = (state_q != ST_IDLE);

endmodule : tlk2711_rx_buf_sched

`default_nettype wire

// File: tb/tb_tlk2711_rx_buf_sched.sv
// ============================================================================
// Module  : tb_tlk2711_rx_buf_sched
// Purpose : Self-checking bench for tlk2711_rx_buf_sched. Expected start
//           addresses and completion records are queued as stimulus is driven
//           and compared when the DUT emits start pulses or pops records.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tlk2711_rx_buf_sched;

  logic        clk;
  logic        rst;
  logic        i_soft_rst;
  logic        i_enable;
  logic [23:0] i_timeout;
  logic        i_desc_valid;
  logic [31:0] i_desc_addr;
  logic        o_desc_ready;
  logic        o_rx_start;
  logic [31:0] o_rx_base_addr;
  logic        o_rx_soft_rst;
  logic        i_rx_interrupt;
  logic [31:0] i_rx_total_packet;
  logic [15:0] i_rx_body_num;
  logic        i_loss_interrupt;
  logic        o_stat_valid;
  logic [31:0] o_stat_addr;
  logic [31:0] o_stat_bytes;
  logic [15:0] o_stat_frames;
  logic [1:0]  o_stat_err;
  logic        i_stat_ready;
  logic        o_busy;
  logic [2:0]  o_ring_level;

  tlk2711_rx_buf_sched #(
    .ADDR_WIDTH (32),
    .RING_DEPTH (4),
    .TMO_WIDTH  (24)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_soft_rst        (i_soft_rst),
    .i_enable          (i_enable),
    .i_timeout         (i_timeout),
    .i_desc_valid      (i_desc_valid),
    .i_desc_addr       (i_desc_addr),
    .o_desc_ready      (o_desc_ready),
    .o_rx_start        (o_rx_start),
    .o_rx_base_addr    (o_rx_base_addr),
    .o_rx_soft_rst     (o_rx_soft_rst),
    .i_rx_interrupt    (i_rx_interrupt),
    .i_rx_total_packet (i_rx_total_packet),
    .i_rx_body_num     (i_rx_body_num),
    .i_loss_interrupt  (i_loss_interrupt),
    .o_stat_valid      (o_stat_valid),
    .o_stat_addr       (o_stat_addr),
    .o_stat_bytes      (o_stat_bytes),
    .o_stat_frames     (o_stat_frames),
    .o_stat_err        (o_stat_err),
    .i_stat_ready      (i_stat_ready),
    .o_busy            (o_busy),
    .o_ring_level      (o_ring_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_starts = 0;

  logic [31:0] exp_start_q [$];
  logic [81:0] exp_stat_q  [$];
  logic [31:0] mon_addr;
  logic [81:0] mon_rec;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [81:0] rec(input logic [31:0] a, input logic [31:0] b,
                                      input logic [15:0] f, input logic [1:0] e);
    return {a, b, f, e};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_desc(input logic [31:0] a);
    int cnt = 0;
    while (!o_desc_ready && cnt < 500) begin tick(); cnt++; end
    check_eq("desc_ready", o_desc_ready, 1'b1);
    i_desc_valid = 1'b1;
    i_desc_addr  = a;
    exp_start_q.push_back(a);
    tick();
    i_desc_valid = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    int cnt = 0;
    while (n_starts < target && cnt < 500) begin tick(); cnt++; end
    check_eq("start_count", n_starts, target);
  endtask

  task automatic wait_drain();
    int cnt = 0;
    while (exp_stat_q.size() != 0 && cnt < 500) begin tick(); cnt++; end
    check_eq("stat_drain", exp_stat_q.size(), 0);
  endtask

  // Scoreboard side: compare start pulses and popped records.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_rx_start) begin
        n_starts++;
        check_eq("start_expected", exp_start_q.size() != 0, 1'b1);
        if (exp_start_q.size() != 0) begin
          mon_addr = exp_start_q.pop_front();
          check_eq("start_addr", o_rx_base_addr, mon_addr);
        end
      end
      if (o_stat_valid && i_stat_ready) begin
        check_eq("stat_expected", exp_stat_q.size() != 0, 1'b1);
        if (exp_stat_q.size() != 0) begin
          mon_rec = exp_stat_q.pop_front();
          check_eq("stat_record", {o_stat_addr, o_stat_bytes, o_stat_frames, o_stat_err}, mon_rec);
        end
      end
    end
  end

  logic [31:0] addrs [8];
  int          s0;
  int          cnt;

  initial begin
    rst = 1'b1; i_soft_rst = 1'b0; i_enable = 1'b0; i_timeout = '0;
    i_desc_valid = 1'b0; i_desc_addr = '0; i_rx_interrupt = 1'b0;
    i_rx_total_packet = '0; i_rx_body_num = '0; i_loss_interrupt = 1'b0;
    i_stat_ready = 1'b0;
    for (int i = 0; i < 8; i++) addrs[i] = 32'h2000_0000 + 32'(i) * 32'h0001_0000;
    tick(3);
    rst = 1'b0;
    tick();

    // Reset state
    check_eq("rst_busy",   o_busy, 1'b0);
    check_eq("rst_level",  o_ring_level, 3'd0);
    check_eq("rst_svalid", o_stat_valid, 1'b0);
    check_eq("rst_ready",  o_desc_ready, 1'b1);
    check_eq("rst_start",  o_rx_start, 1'b0);
    check_eq("rst_base",   o_rx_base_addr, 32'h0);
    check_eq("rst_srst",   o_rx_soft_rst, 1'b0);
    check_eq("rst_saddr",  o_stat_addr, 32'h0);

    // 1: single buffer, interrupt-to-valid latency
    i_enable = 1'b1;
    push_desc(32'h1000_0000);
    wait_starts(1);
    tick();
    check_eq("t1_base_hold", o_rx_base_addr, 32'h1000_0000);
    i_rx_total_packet = 32'd5120;
    i_rx_body_num     = 16'd4;
    exp_stat_q.push_back(rec(32'h1000_0000, 32'd5120, 16'd4, 2'b00));
    i_rx_interrupt = 1'b1;
    tick();
    check_eq("t1_lat_c1", o_stat_valid, 1'b0);
    tick();
    check_eq("t1_lat_c2", o_stat_valid, 1'b1);
    i_rx_interrupt = 1'b0;
    i_stat_ready = 1'b1;
    wait_drain();
    check_eq("t1_idle", o_busy, 1'b0);

    // 2: three buffers, interrupt held high 20 cycles each
    s0 = n_starts;
    for (int k = 0; k < 3; k++) push_desc(addrs[k]);
    for (int k = 0; k < 3; k++) begin
      wait_starts(s0 + k + 1);
      tick(2);
      check_eq("t2_base_hold", o_rx_base_addr, addrs[k]);
      i_rx_total_packet = i_rx_total_packet + 32'd100 * 32'(k + 1);
      i_rx_body_num     = i_rx_body_num + 16'(k + 1);
      exp_stat_q.push_back(rec(addrs[k], 32'd100 * 32'(k + 1), 16'(k + 1), 2'b00));
      i_rx_interrupt = 1'b1;
      tick(20);
      i_rx_interrupt = 1'b0;
      tick(2);
    end
    wait_drain();
    tick(10);
    check_eq("t2_starts", n_starts, s0 + 3);
    check_eq("t2_idle", o_busy, 1'b0);

    // 3: counter wrap
    i_rx_total_packet = 32'hFFFF_FF00;
    i_rx_body_num     = 16'hFFFE;
    s0 = n_starts;
    push_desc(addrs[3]);
    wait_starts(s0 + 1);
    tick(2);
    i_rx_total_packet = 32'h0000_0100;
    i_rx_body_num     = 16'h0001;
    exp_stat_q.push_back(rec(addrs[3], 32'h200, 16'd3, 2'b00));
    i_rx_interrupt = 1'b1;
    tick();
    i_rx_interrupt = 1'b0;
    wait_drain();

    // Loss together with interrupt: err[0], counts as complete, link flush
    s0 = n_starts;
    push_desc(addrs[4]);
    wait_starts(s0 + 1);
    tick(2);
    i_rx_total_packet = i_rx_total_packet + 32'd10;
    i_rx_body_num     = i_rx_body_num + 16'd2;
    exp_stat_q.push_back(rec(addrs[4], 32'd10, 16'd2, 2'b01));
    i_loss_interrupt = 1'b1;
    i_rx_interrupt   = 1'b1;
    tick();
    i_loss_interrupt = 1'b0;
    i_rx_interrupt   = 1'b0;
    check_eq("loss_srst", o_rx_soft_rst, 1'b1);
    tick();
    check_eq("loss_srst_end", o_rx_soft_rst, 1'b0);
    check_eq("loss_idle", o_busy, 1'b0);
    wait_drain();

    // 4: timeout of 100 cycles with no interrupt
    i_timeout = 24'd100;
    exp_stat_q.push_back(rec(addrs[5], 32'd0, 16'd0, 2'b10));
    push_desc(addrs[5]);
    cnt = 0;
    while (!o_rx_start && cnt < 50) begin tick(); cnt++; end
    check_eq("t4_start_seen", o_rx_start, 1'b1);
    cnt = 0;
    while (!o_rx_soft_rst && cnt < 300) begin tick(); cnt++; end
    check_eq("t4_tmo_latency", cnt, 102);
    tick();
    check_eq("t4_srst_end", o_rx_soft_rst, 1'b0);
    check_eq("t4_idle", o_busy, 1'b0);
    wait_drain();
    i_timeout = 24'd0;

    // 5: status queue full stalls the fifth buffer in DONE
    i_stat_ready = 1'b0;
    s0 = n_starts;
    for (int k = 0; k < 5; k++) push_desc(32'h3000_0000 + 32'(k) * 32'h100);
    for (int k = 0; k < 5; k++) begin
      wait_starts(s0 + k + 1);
      tick(2);
      i_rx_total_packet = i_rx_total_packet + 32'd64;
      i_rx_body_num     = i_rx_body_num + 16'd1;
      exp_stat_q.push_back(rec(32'h3000_0000 + 32'(k) * 32'h100, 32'd64, 16'd1, 2'b00));
      i_rx_interrupt = 1'b1;
      tick();
      i_rx_interrupt = 1'b0;
      tick(2);
    end
    tick(10);
    check_eq("t5_starts", n_starts, s0 + 5);
    check_eq("t5_stall_busy", o_busy, 1'b1);
    check_eq("t5_svalid", o_stat_valid, 1'b1);
    push_desc(32'h3000_0500);
    tick(5);
    check_eq("t5_no_6th", n_starts, s0 + 5);
    check_eq("t5_ring1", o_ring_level, 3'd1);
    i_enable = 1'b0;
    i_stat_ready = 1'b1;
    tick();
    i_stat_ready = 1'b0;
    tick(3);
    check_eq("t5_released", o_busy, 1'b0);
    check_eq("t5_no_6th_after", n_starts, s0 + 5);
    i_stat_ready = 1'b1;
    wait_drain();

    // 6: soft reset mid-ARMED with two descriptors still queued
    push_desc(32'h3000_0600);
    push_desc(32'h3000_0700);
    i_enable = 1'b1;
    wait_starts(s0 + 6);
    tick(2);
    check_eq("t6_ring2", o_ring_level, 3'd2);
    check_eq("t6_armed", o_busy, 1'b1);
    i_soft_rst = 1'b1;
    tick();
    i_soft_rst = 1'b0;
    exp_start_q.delete();
    check_eq("t6_busy", o_busy, 1'b0);
    check_eq("t6_ring0", o_ring_level, 3'd0);
    check_eq("t6_svalid", o_stat_valid, 1'b0);
    check_eq("t6_start", o_rx_start, 1'b0);
    tick(10);
    check_eq("t6_no_start", n_starts, s0 + 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tlk2711_rx_buf_sched

`default_nettype wire
